// File: rtl/fft_frame_controller.sv
`default_nettype none
// ============================================================================
// Module      : fft_frame_controller
// Description : Frame sequencing FSM between a sample source and a streaming
//               FFT core: load, process watchdog, unload length check.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_frame_controller #(
    parameter int NFFT_LOG2   = 10,
    parameter int SCALE_W     = 10,
    parameter int TIMEOUT_W   = 16,
    parameter int TIMEOUT_CYC = 40000,
    parameter int FRAME_W     = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ready,
    input  logic                 mode_cont,
    input  logic                 go,
    input  logic [SCALE_W-1:0]   scale_sch_in,
    input  logic                 clear_err,
    input  logic                 e_done_fft_core,
    input  logic                 dv_fft_core,
    output logic                 sclr_fft_core,
    output logic                 scale_sch_we_fft_core,
    output logic [SCALE_W-1:0]   scale_sch_fft_core,
    output logic                 start_fft_core,
    output logic                 unload_fft_core,
    output logic                 load_en,
    output logic [NFFT_LOG2-1:0] load_idx,
    output logic                 frame_done,
    output logic [FRAME_W-1:0]   frame_cnt,
    output logic                 busy,
    output logic                 timeout_err,
    output logic                 len_err
);

    typedef enum logic [3:0] {
        RESET_ST    = 4'd0,
        SET_SCALING = 4'd1,
        START_FFT   = 4'd2,
        LOAD_FFT    = 4'd3,
        WAIT_PROC   = 4'd4,
        UNLOAD_EN   = 4'd5,
        WAIT_DV     = 4'd6,
        UNLOAD      = 4'd7,
        ERROR_ST    = 4'd8
    } state_t;

    localparam logic [NFFT_LOG2-1:0] c_IDX_ONE  = NFFT_LOG2'(1);
    localparam logic [NFFT_LOG2-1:0] c_IDX_LAST = '1;
    localparam logic [NFFT_LOG2:0]   c_UCNT_ONE = (NFFT_LOG2 + 1)'(1);
    localparam logic [NFFT_LOG2:0]   c_N        = {1'b1, {NFFT_LOG2{1'b0}}};
    // Unload count stops at N+1 so an over-long burst never wraps back onto N.
    localparam logic [NFFT_LOG2:0]   c_N_PLUS1  = c_N + c_UCNT_ONE;
    localparam logic [TIMEOUT_W-1:0] c_WD_ONE   = TIMEOUT_W'(1);
    localparam logic [TIMEOUT_W-1:0] c_WD_LAST  = TIMEOUT_W'(TIMEOUT_CYC - 1);
    localparam logic [FRAME_W-1:0]   c_FCNT_ONE = FRAME_W'(1);

    state_t                 state_q, state_d;
    logic [NFFT_LOG2-1:0]   idx_q, idx_d;
    logic [TIMEOUT_W-1:0]   wd_q, wd_d;
    logic [NFFT_LOG2:0]     ucnt_q, ucnt_d;
    logic [SCALE_W-1:0]     scale_q, scale_d;
    logic [FRAME_W-1:0]     fcnt_q, fcnt_d;
    logic                   terr_q, terr_d;
    logic                   lerr_q, lerr_d;

    logic                   sclr_d_o;
    logic                   we_d_o;
    logic                   start_d_o;
    logic                   unload_d_o;
    logic                   load_en_d_o;
    logic                   busy_d_o;
    logic                   fdone_d_o;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= RESET_ST;
            idx_q   <= '0;
            wd_q    <= '0;
            ucnt_q  <= '0;
            scale_q <= '0;
            fcnt_q  <= '0;
            terr_q  <= 1'b0;
            lerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wd_q    <= wd_d;
            ucnt_q  <= ucnt_d;
            scale_q <= scale_d;
            fcnt_q  <= fcnt_d;
            terr_q  <= terr_d;
            lerr_q  <= lerr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = '0;
        wd_d        = '0;
        ucnt_d      = ucnt_q;
        scale_d     = scale_q;
        fcnt_d      = fcnt_q;
        // Clear first so a set in the same cycle below takes priority.
        terr_d      = clear_err ? 1'b0 : terr_q;
        lerr_d      = clear_err ? 1'b0 : lerr_q;
        sclr_d_o    = 1'b0;
        we_d_o      = 1'b0;
        start_d_o   = 1'b0;
        unload_d_o  = 1'b0;
        load_en_d_o = 1'b0;
        busy_d_o    = 1'b0;
        fdone_d_o   = 1'b0;

        case (state_q)
            RESET_ST: begin
                sclr_d_o = 1'b1;
                state_d  = SET_SCALING;
            end
            SET_SCALING: begin
                we_d_o  = 1'b1;
                scale_d = scale_sch_in;
                if (ready && (mode_cont || go)) begin
                    state_d = START_FFT;
                end
            end
            START_FFT: begin
                start_d_o   = 1'b1;
                load_en_d_o = 1'b1;
                busy_d_o    = 1'b1;
                idx_d       = c_IDX_ONE;
                state_d     = LOAD_FFT;
            end
            LOAD_FFT: begin
                load_en_d_o = 1'b1;
                busy_d_o    = 1'b1;
                if (idx_q == c_IDX_LAST) begin
                    state_d = WAIT_PROC;
                end else begin
                    idx_d = idx_q + c_IDX_ONE;
                end
            end
            WAIT_PROC: begin
                busy_d_o = 1'b1;
                wd_d     = wd_q + c_WD_ONE;
                if (e_done_fft_core) begin
                    state_d = UNLOAD_EN;
                end else if (wd_q == c_WD_LAST) begin
                    state_d = ERROR_ST;
                end
            end
            UNLOAD_EN: begin
                unload_d_o = 1'b1;
                busy_d_o   = 1'b1;
                state_d    = WAIT_DV;
            end
            WAIT_DV: begin
                busy_d_o = 1'b1;
                wd_d     = wd_q + c_WD_ONE;
                if (dv_fft_core) begin
                    ucnt_d  = c_UCNT_ONE;
                    state_d = UNLOAD;
                end else if (wd_q == c_WD_LAST) begin
                    state_d = ERROR_ST;
                end
            end
            UNLOAD: begin
                busy_d_o = 1'b1;
                if (dv_fft_core) begin
                    if (ucnt_q != c_N_PLUS1) begin
                        ucnt_d = ucnt_q + c_UCNT_ONE;
                    end
                end else begin
                    fdone_d_o = 1'b1;
                    fcnt_d    = fcnt_q + c_FCNT_ONE;
                    if (ucnt_q != c_N) begin
                        lerr_d = 1'b1;
                    end
                    state_d = (mode_cont && ready) ? START_FFT : SET_SCALING;
                end
            end
            ERROR_ST: begin
                sclr_d_o = 1'b1;
                terr_d   = 1'b1;
                state_d  = RESET_ST;
            end
            default: begin
                state_d = RESET_ST;
            end
        endcase
    end

    assign sclr_fft_core         = sclr_d_o;
    assign scale_sch_we_fft_core = we_d_o;
    assign scale_sch_fft_core    = scale_q;
    assign start_fft_core        = start_d_o;
    assign unload_fft_core       = unload_d_o;
    assign load_en               = load_en_d_o;
    assign load_idx              = idx_q;
    assign frame_done            = fdone_d_o;
    assign frame_cnt             = fcnt_q;
    assign busy                  = busy_d_o;
    assign timeout_err           = terr_q;
    assign len_err               = lerr_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_controller.sv
`default_nettype none
// Testbench for fft_frame_controller: frame-level expected traces built from
// phase/length arithmetic, a hand-derived vector table and randomized frames.
module tb_fft_frame_controller;

    localparam int NL = 4;
    localparam int N  = 16;
    localparam int SW = 10;
    localparam int TW = 16;
    localparam int TC = 64;
    localparam int FW = 2;

    typedef enum int {P_RST, P_SET, P_START, P_LOAD, P_WPROC, P_UEN, P_WDV, P_UNL, P_ERR} ph_t;

    typedef struct {
        int edly;
        int dwait;
        int dlen;
        bit cont;
        bit rdy;
        bit clr;
        int fcnt;
        bit lerr;
        bit terr;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, ready, mode_cont, go, clear_err, e_done, dv;
    logic [SW-1:0] sch_in;
    logic          sclr, we, start, unload, load_en, frame_done, busy, terr, lerr;
    logic [SW-1:0] scale;
    logic [NL-1:0] load_idx;
    logic [FW-1:0] frame_cnt;

    fft_frame_controller #(
        .NFFT_LOG2(NL), .SCALE_W(SW), .TIMEOUT_W(TW), .TIMEOUT_CYC(TC), .FRAME_W(FW)
    ) dut (
        .clock(clk), .reset(rst_n), .ready(ready), .mode_cont(mode_cont), .go(go),
        .scale_sch_in(sch_in), .clear_err(clear_err), .e_done_fft_core(e_done),
        .dv_fft_core(dv), .sclr_fft_core(sclr), .scale_sch_we_fft_core(we),
        .scale_sch_fft_core(scale), .start_fft_core(start), .unload_fft_core(unload),
        .load_en(load_en), .load_idx(load_idx), .frame_done(frame_done),
        .frame_cnt(frame_cnt), .busy(busy), .timeout_err(terr), .len_err(lerr)
    );

    int            total = 0;
    int            bad   = 0;
    logic [SW-1:0] m_scale;
    int            m_fcnt;
    bit            m_terr, m_lerr;
    bit            in_set, pend_frame, pend_len, pend_terr;
    vec_t          vt[11];

    // Advance one clock; fold the closing cycle's effects into the model.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            m_scale = '0; m_fcnt = 0; m_terr = 1'b0; m_lerr = 1'b0;
        end else begin
            if (in_set) m_scale = sch_in;
            if (clear_err) begin m_terr = 1'b0; m_lerr = 1'b0; end
            if (pend_frame) m_fcnt = (m_fcnt + 1) % (1 << FW);
            if (pend_len) m_lerr = 1'b1;
            if (pend_terr) m_terr = 1'b1;
        end
        in_set = 1'b0; pend_frame = 1'b0; pend_len = 1'b0; pend_terr = 1'b0;
        #1;
        sch_in = SW'($urandom);
        e_done = 1'b0; dv = 1'b0; go = 1'b0; clear_err = 1'b0;
    endtask

    task automatic chk(input string nm, input ph_t p, input int idx, input bit fd);
        logic [24:0] e, a;
        #1;
        in_set = (p == P_SET);
        if (p == P_ERR) pend_terr = 1'b1;
        e = {(p == P_RST) || (p == P_ERR), p == P_SET, p == P_START, p == P_UEN,
             (p == P_START) || (p == P_LOAD),
             p inside {P_START, P_LOAD, P_WPROC, P_UEN, P_WDV, P_UNL},
             fd, m_terr, m_lerr, NL'(idx), FW'(m_fcnt), m_scale};
        a = {sclr, we, start, unload, load_en, busy, frame_done, terr, lerr,
             load_idx, frame_cnt, scale};
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s phase=%0d: got %h want %h", nm, p, a, e);
        end
    endtask

    task automatic chk_vec(input string nm, input vec_t v);
        logic [FW+1:0] e, a;
        e = {FW'(v.fcnt), v.lerr, v.terr};
        a = {frame_cnt, lerr, terr};
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s flags: got %h want %h", nm, a, e);
        end
    endtask

    // Entered in a START_FFT cycle that the caller has already checked.
    task automatic run_frame(input string nm, input int edly, input int dwait, input int dlen,
                             input bit cont, input bit rdy, input bit clr, output bit ends_set);
        for (int i = 1; i < N; i++) begin tick(); chk(nm, P_LOAD, i, 1'b0); end
        if (edly >= TC) begin
            for (int k = 0; k < TC; k++) begin tick(); chk(nm, P_WPROC, 0, 1'b0); end
            tick(); chk(nm, P_ERR, 0, 1'b0);
            tick(); chk(nm, P_RST, 0, 1'b0);
            tick(); ends_set = 1'b1;
            return;
        end
        for (int k = 0; k < edly; k++) begin tick(); chk(nm, P_WPROC, 0, 1'b0); end
        tick(); e_done = 1'b1; chk(nm, P_WPROC, 0, 1'b0);
        tick(); chk(nm, P_UEN, 0, 1'b0);
        if (dwait >= TC) begin
            for (int k = 0; k < TC; k++) begin tick(); chk(nm, P_WDV, 0, 1'b0); end
            tick(); chk(nm, P_ERR, 0, 1'b0);
            tick(); chk(nm, P_RST, 0, 1'b0);
            tick(); ends_set = 1'b1;
            return;
        end
        for (int k = 0; k < dwait; k++) begin tick(); chk(nm, P_WDV, 0, 1'b0); end
        tick(); dv = 1'b1; chk(nm, P_WDV, 0, 1'b0);
        for (int j = 2; j <= dlen; j++) begin tick(); dv = 1'b1; chk(nm, P_UNL, 0, 1'b0); end
        tick();
        mode_cont = cont; ready = rdy; clear_err = clr;
        chk(nm, P_UNL, 0, 1'b1);
        pend_frame = 1'b1;
        pend_len   = (dlen != N);
        tick();
        ends_set = !(cont && rdy);
    endtask

    initial begin
        bit ends_set;
        string nm;

        rst_n = 1'b0; ready = 1'b0; mode_cont = 1'b0; go = 1'b0; clear_err = 1'b0;
        e_done = 1'b0; dv = 1'b0; sch_in = '0;
        m_scale = '0; m_fcnt = 0; m_terr = 1'b0; m_lerr = 1'b0;
        in_set = 1'b0; pend_frame = 1'b0; pend_len = 1'b0; pend_terr = 1'b0;

        //        edly dwait dlen cont rdy clr | fcnt lerr terr
        vt[0]  = '{5,  0,  16, 1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0};
        vt[1]  = '{0,  2,  12, 1'b1, 1'b1, 1'b0, 2, 1'b1, 1'b0};
        vt[2]  = '{63, 1,  16, 1'b0, 1'b1, 1'b1, 3, 1'b0, 1'b0};
        vt[3]  = '{64, 0,  16, 1'b1, 1'b1, 1'b0, 3, 1'b0, 1'b1};
        vt[4]  = '{3,  64, 16, 1'b1, 1'b1, 1'b0, 3, 1'b0, 1'b1};
        vt[5]  = '{1,  0,  17, 1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b0};
        vt[6]  = '{2,  3,  48, 1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b0};
        vt[7]  = '{0,  0,  1,  1'b0, 1'b1, 1'b1, 2, 1'b1, 1'b0};
        vt[8]  = '{4,  0,  16, 1'b1, 1'b1, 1'b1, 3, 1'b0, 1'b0};
        vt[9]  = '{4,  0,  16, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        vt[10] = '{4,  0,  16, 1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0};

        tick(); tick();
        chk("reset", P_RST, 0, 1'b0);
        rst_n = 1'b1;
        tick(); chk("post_reset", P_SET, 0, 1'b0);

        // Single-shot: parked in SET_SCALING until go.
        mode_cont = 1'b0; ready = 1'b1;
        for (int k = 0; k < 19; k++) begin tick(); chk("go_wait", P_SET, 0, 1'b0); end
        tick(); go = 1'b1; chk("go_cycle", P_SET, 0, 1'b0);
        tick(); chk("go_start", P_START, 0, 1'b0);

        for (int v = 0; v < 11; v++) begin
            nm = $sformatf("vec%0d", v);
            run_frame(nm, vt[v].edly, vt[v].dwait, vt[v].dlen,
                      vt[v].cont, vt[v].rdy, vt[v].clr, ends_set);
            chk(nm, ends_set ? P_SET : P_START, 0, 1'b0);
            chk_vec(nm, vt[v]);
            if (ends_set) begin
                mode_cont = 1'b1; ready = 1'b1;
                tick(); chk(nm, P_START, 0, 1'b0);
            end
        end

        for (int r = 0; r < 30; r++) begin
            int edly, dwait, dlen;
            bit cont, rdy, clr;
            nm    = $sformatf("rnd%0d", r);
            edly  = ($urandom_range(0, 7) == 0) ? TC : int'($urandom_range(0, 20));
            dwait = ($urandom_range(0, 7) == 0) ? TC : int'($urandom_range(0, 5));
            dlen  = ($urandom_range(0, 1) == 0) ? N : int'($urandom_range(1, 20));
            cont  = 1'($urandom_range(0, 1));
            rdy   = 1'($urandom_range(0, 1));
            clr   = 1'($urandom_range(0, 1));
            run_frame(nm, edly, dwait, dlen, cont, rdy, clr, ends_set);
            chk(nm, ends_set ? P_SET : P_START, 0, 1'b0);
            if (ends_set) begin
                int idle;
                idle  = int'($urandom_range(0, 3));
                ready = 1'b0;
                for (int k = 0; k < idle; k++) begin
                    tick();
                    clear_err = 1'($urandom_range(0, 1));
                    chk(nm, P_SET, 0, 1'b0);
                end
                mode_cont = 1'b1; ready = 1'b1;
                tick(); chk(nm, P_START, 0, 1'b0);
            end
        end

        // Abort in the middle of a load.
        for (int i = 1; i <= 7; i++) begin tick(); chk("pre_abort", P_LOAD, i, 1'b0); end
        rst_n = 1'b0;
        tick(); chk("mid_reset", P_RST, 0, 1'b0);
        rst_n = 1'b1;
        tick(); chk("after_abort", P_SET, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
